// File: rtl/controlador_contador.sv
// controlador_contador
// Sequencing controller for a LARGURA-bit up/down/load counter datapath.
// It decides every cycle whether the counter counts, in which direction and
// when it reloads, in ping-pong or circular mode, for a programmed lap count.
module controlador_contador #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               parar,
    input  logic               modo,
    input  logic [LARGURA-1:0] limite_inf,
    input  logic [LARGURA-1:0] limite_sup,
    input  logic [7:0]         voltas,
    input  logic [LARGURA-1:0] contagem,
    output logic               habilita,
    output logic               sobe,
    output logic               carrega,
    output logic [LARGURA-1:0] valor_carga,
    output logic               ocupado,
    output logic               fim,
    output logic [7:0]         voltas_feitas
);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        CARGA    = 2'd1,
        SUBINDO  = 2'd2,
        DESCENDO = 2'd3
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] inf_q, inf_d;
    logic [LARGURA-1:0] sup_q, sup_d;
    logic               modo_q, modo_d;
    logic [7:0]         voltas_q, voltas_d;
    logic [7:0]         feitas_q, feitas_d;
    logic               voltaFinal;
    logic               voltaCompleta;

    // The lap that is completing now is the last one when a finite run length
    // was programmed and this lap brings the completed count up to it.
    assign voltaFinal = (voltas_q != 8'd0) &&
                        (({1'b0, feitas_q} + 9'd1) == {1'b0, voltas_q});

    assign valor_carga   = inf_q;
    assign voltas_feitas = feitas_q;
    assign ocupado       = (estado_q != PARADO);

    // State and latched configuration registers; everything clears on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= PARADO;
            inf_q    <= '0;
            sup_q    <= '0;
            modo_q   <= 1'b0;
            voltas_q <= 8'd0;
            feitas_q <= 8'd0;
        end else begin
            estado_q <= estado_d;
            inf_q    <= inf_d;
            sup_q    <= sup_d;
            modo_q   <= modo_d;
            voltas_q <= voltas_d;
            feitas_q <= feitas_d;
        end
    end

    // Next state and strobes; an abort always wins over limit handling so the
    // counter never moves on the cycle parar is seen.
    always_comb begin
        estado_d      = estado_q;
        inf_d         = inf_q;
        sup_d         = sup_q;
        modo_d        = modo_q;
        voltas_d      = voltas_q;
        feitas_d      = feitas_q;
        habilita      = 1'b0;
        sobe          = 1'b0;
        carrega       = 1'b0;
        fim           = 1'b0;
        voltaCompleta = 1'b0;

        case (estado_q)
            PARADO: begin
                if (iniciar && (limite_inf < limite_sup)) begin
                    estado_d = CARGA;
                    inf_d    = limite_inf;
                    sup_d    = limite_sup;
                    modo_d   = modo;
                    voltas_d = voltas;
                    feitas_d = 8'd0;
                end
            end
            CARGA: begin
                if (parar) begin
                    estado_d = PARADO;
                end else begin
                    carrega  = 1'b1;
                    estado_d = SUBINDO;
                end
            end
            SUBINDO: begin
                if (parar) begin
                    estado_d = PARADO;
                end else if (contagem < sup_q) begin
                    habilita = 1'b1;
                    sobe     = 1'b1;
                end else if (!modo_q) begin
                    habilita = 1'b1;
                    estado_d = DESCENDO;
                end else begin
                    voltaCompleta = 1'b1;
                    if (voltaFinal) begin
                        fim      = 1'b1;
                        estado_d = PARADO;
                    end else begin
                        carrega = 1'b1;
                    end
                end
            end
            DESCENDO: begin
                if (parar) begin
                    estado_d = PARADO;
                end else if (contagem > inf_q) begin
                    habilita = 1'b1;
                end else begin
                    voltaCompleta = 1'b1;
                    if (voltaFinal) begin
                        fim      = 1'b1;
                        estado_d = PARADO;
                    end else begin
                        habilita = 1'b1;
                        sobe     = 1'b1;
                        estado_d = SUBINDO;
                    end
                end
            end
            default: begin
                estado_d = PARADO;
            end
        endcase

        if (voltaCompleta && (feitas_q != 8'hFF)) begin
            feitas_d = feitas_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_controlador_contador.sv
// tb_controlador_contador
// Directed bench for controlador_contador with a behavioral up/down/load
// counter closing the loop through contagem.
module tb_controlador_contador;

    localparam int LARGURA = 4;

    logic               clock;
    logic               reset;
    logic               iniciar;
    logic               parar;
    logic               modo;
    logic [LARGURA-1:0] limite_inf;
    logic [LARGURA-1:0] limite_sup;
    logic [7:0]         voltas;
    logic [LARGURA-1:0] contagem;
    logic               habilita;
    logic               sobe;
    logic               carrega;
    logic [LARGURA-1:0] valor_carga;
    logic               ocupado;
    logic               fim;
    logic [7:0]         voltas_feitas;

    int vectorCount;
    int missCount;
    int sawFim;

    controlador_contador #(.LARGURA(LARGURA)) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .parar         (parar),
        .modo          (modo),
        .limite_inf    (limite_inf),
        .limite_sup    (limite_sup),
        .voltas        (voltas),
        .contagem      (contagem),
        .habilita      (habilita),
        .sobe          (sobe),
        .carrega       (carrega),
        .valor_carga   (valor_carga),
        .ocupado       (ocupado),
        .fim           (fim),
        .voltas_feitas (voltas_feitas)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioral counter datapath: load wins over count, holds otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (carrega) begin
            contagem <= valor_carga;
        end else if (habilita) begin
            contagem <= sobe ? contagem + 1'b1 : contagem - 1'b1;
        end
    end

    // Advance one full cycle and land on the falling edge for sampling.
    task automatic applyStimulus();
        @(posedge clock);
        @(negedge clock);
    endtask

    // One comparison: counts it, and reports a miscompare with its tag.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Arm a run configuration with a one-cycle iniciar pulse.
    task automatic startRun(input logic m, input int inf, input int sup, input int nv);
        modo       = m;
        limite_inf = inf[LARGURA-1:0];
        limite_sup = sup[LARGURA-1:0];
        voltas     = nv[7:0];
        iniciar    = 1'b1;
        applyStimulus();
        iniciar    = 1'b0;
    endtask

    // Directed sequence: reset, ping-pong, circular, invalid limits, abort,
    // asynchronous reset mid-run and lap-count saturation.
    initial begin
        int ppSeq[13];
        int ciSeq[12];
        ppSeq = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
        ciSeq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        vectorCount = 0;
        missCount   = 0;
        sawFim      = 0;
        reset       = 1'b0;
        iniciar     = 1'b0;
        parar       = 1'b0;
        modo        = 1'b0;
        limite_inf  = '0;
        limite_sup  = '0;
        voltas      = 8'd0;

        @(negedge clock);
        checkOutput("reset ocupado", ocupado, 0);
        checkOutput("reset habilita", habilita, 0);
        checkOutput("reset carrega", carrega, 0);
        checkOutput("reset fim", fim, 0);
        checkOutput("reset valor_carga", valor_carga, 0);
        checkOutput("reset voltas_feitas", voltas_feitas, 0);
        applyStimulus();
        reset = 1'b1;
        applyStimulus();

        $display("[TB] ping-pong 2..5, 2 laps, with ignored mid-run inputs");
        startRun(1'b0, 2, 5, 2);
        checkOutput("pp carga carrega", carrega, 1);
        checkOutput("pp carga habilita", habilita, 0);
        checkOutput("pp carga ocupado", ocupado, 1);
        checkOutput("pp valor_carga", valor_carga, 2);
        applyStimulus();
        for (int i = 0; i < 13; i++) begin
            checkOutput($sformatf("pp contagem[%0d]", i), contagem, ppSeq[i]);
            checkOutput($sformatf("pp fim[%0d]", i), fim, (i == 12) ? 1 : 0);
            if (i == 1) begin
                iniciar    = 1'b1;
                limite_sup = 4'd9;
            end
            if (i == 2) iniciar = 1'b0;
            applyStimulus();
        end
        checkOutput("pp end ocupado", ocupado, 0);
        checkOutput("pp end fim", fim, 0);
        checkOutput("pp end voltas_feitas", voltas_feitas, 2);
        applyStimulus();
        checkOutput("pp hold contagem", contagem, 2);

        $display("[TB] circular 0..3, 3 laps");
        startRun(1'b1, 0, 3, 3);
        checkOutput("ci carga carrega", carrega, 1);
        applyStimulus();
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("ci contagem[%0d]", i), contagem, ciSeq[i]);
            checkOutput($sformatf("ci carrega[%0d]", i), carrega, (i == 3 || i == 7) ? 1 : 0);
            checkOutput($sformatf("ci fim[%0d]", i), fim, (i == 11) ? 1 : 0);
            applyStimulus();
        end
        checkOutput("ci end ocupado", ocupado, 0);
        checkOutput("ci end voltas_feitas", voltas_feitas, 3);

        $display("[TB] invalid limits");
        startRun(1'b0, 7, 7, 1);
        checkOutput("inv 7/7 ocupado", ocupado, 0);
        checkOutput("inv 7/7 voltas_feitas", voltas_feitas, 3);
        startRun(1'b0, 9, 4, 1);
        checkOutput("inv 9/4 ocupado", ocupado, 0);
        checkOutput("inv 9/4 voltas_feitas", voltas_feitas, 3);
        checkOutput("inv valor_carga", valor_carga, 0);

        $display("[TB] abort in DESCENDO at 4, range 1..6");
        startRun(1'b0, 1, 6, 0);
        applyStimulus();
        for (int i = 0; i < 7; i++) applyStimulus();
        checkOutput("abort pre contagem", contagem, 4);
        checkOutput("abort pre habilita", habilita, 1);
        parar = 1'b1;
        #1;
        checkOutput("abort habilita", habilita, 0);
        checkOutput("abort carrega", carrega, 0);
        checkOutput("abort fim", fim, 0);
        applyStimulus();
        parar = 1'b0;
        checkOutput("abort ocupado", ocupado, 0);
        checkOutput("abort voltas_feitas", voltas_feitas, 0);
        applyStimulus();
        checkOutput("abort hold contagem", contagem, 4);

        $display("[TB] restart, then asynchronous reset mid-run");
        startRun(1'b0, 1, 6, 0);
        applyStimulus();
        checkOutput("restart contagem", contagem, 1);
        applyStimulus();
        checkOutput("restart step contagem", contagem, 2);
        checkOutput("restart sobe", sobe, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async ocupado", ocupado, 0);
        checkOutput("async habilita", habilita, 0);
        checkOutput("async sobe", sobe, 0);
        checkOutput("async carrega", carrega, 0);
        checkOutput("async fim", fim, 0);
        applyStimulus();
        reset = 1'b1;
        applyStimulus();

        $display("[TB] circular 0..1 forever, 300 laps for saturation");
        startRun(1'b1, 0, 1, 0);
        applyStimulus();
        for (int i = 0; i < 610; i++) begin
            if (fim) sawFim = 1;
            applyStimulus();
        end
        checkOutput("sat fim never", sawFim, 0);
        checkOutput("sat voltas_feitas", voltas_feitas, 255);
        checkOutput("sat ocupado", ocupado, 1);
        parar = 1'b1;
        applyStimulus();
        parar = 1'b0;
        checkOutput("sat stop ocupado", ocupado, 0);
        checkOutput("sat stop voltas_feitas", voltas_feitas, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
